sign_window_monitor: RTL and testbench
======================================

Name: sign_window_monitor

Overview:
- Downstream consumer of the 8-bit less-than-zero check: accepts a stream of signed samples, derives the negative flag internally (sign bit), and collects per-window statistics.
- Per window of WINDOW samples it reports the negative-sample count, the longest consecutive negative run, and an alarm when that run reaches RUN_LIMIT.
- Sits between a sample producer (valid/ready) and a result consumer (valid/ready with backpressure).

Parameters:
- WIDTH, 8, sample width in bits; samples are two's complement.
- WINDOW, 16, samples per window; must be >= 2.
- RUN_LIMIT, 4, run length at which ALARM asserts; must be 1..WINDOW.
- CW, $clog2(WINDOW+1), derived width of the count outputs; not overridden.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle pulse that begins the first window; sampled only in IDLE.
- CONT  input  1  sampled at the result handshake: 1 = start the next window immediately, 0 = return to IDLE.
- IN_VALID  input  1  sample A is valid.
- IN_READY  output  1  block accepts a sample this cycle.
- A  input  WIDTH  signed sample.
- OUT_VALID  output  1  result fields are valid.
- OUT_READY  input  1  consumer accepts the result.
- NEG_COUNT  output  CW  number of negative samples (A < 0) in the window.
- MAX_RUN  output  CW  longest run of consecutive negative samples in the window.
- ALARM  output  1  MAX_RUN >= RUN_LIMIT.
- BUSY  output  1  high in COUNT and REPORT.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; internal counters 0; IN_READY, OUT_VALID, ALARM and BUSY are 0; NEG_COUNT and MAX_RUN are 0.
- States and transitions:
  - IDLE: IN_READY=0, OUT_VALID=0. START=1 moves to COUNT next edge and clears sample count, negative count, current run and max run.
  - COUNT: IN_READY=1 (combinational from state). A sample is accepted when IN_VALID and IN_READY are both 1 at an edge.
  - REPORT: IN_READY=0, OUT_VALID=1. Result fields are held stable until the handshake.
- Per accepted sample, with neg = A[WIDTH-1]:
  - sample count +1; negative count +neg.
  - run_next = neg ? run+1 : 0.
  - max_next = max(max, run_next).
- Window close: the WINDOW-th accepted sample moves the block to REPORT on the same edge.
  - NEG_COUNT, MAX_RUN and ALARM are registered from the updated values, so that last sample is included.
  - OUT_VALID rises in the cycle after the last sample is accepted (1-cycle latency).
- REPORT exit: the handshake is OUT_VALID and OUT_READY both 1 at an edge.
  - CONT=1: go to COUNT and clear all counters; the next sample is accepted the cycle after the handshake.
  - CONT=0: go to IDLE.
  - OUT_VALID may stay high indefinitely while OUT_READY=0; nothing changes and no input is accepted.
- Result outputs outside REPORT: NEG_COUNT, MAX_RUN and ALARM keep the last reported values in IDLE and COUNT; only OUT_VALID qualifies them.
- Boundaries:
  - A = 0 counts as non-negative; A = 8'h80 (-128) counts as negative.
  - A run never carries across windows.
  - All-negative window: NEG_COUNT = MAX_RUN = WINDOW.
  - No counter wraps: maximum value is WINDOW, which fits in CW bits.
  - START is ignored in COUNT and REPORT.
  - IN_VALID held high in IDLE or REPORT: the sample is not consumed.
  - RST_N asserted mid-window or mid-REPORT: immediate return to reset state; the partial window is discarded and no result is emitted.

Test Plan (WINDOW=8, RUN_LIMIT=3 overridden; WIDTH=8):
- Reset then START, 8 samples 0,1,2,3,4,5,6,7 with IN_VALID continuously high -> OUT_VALID the cycle after the 8th accept; NEG_COUNT=0, MAX_RUN=0, ALARM=0.
- Samples -1,-2,5,-3,-4,-5,0,-128 -> NEG_COUNT=6, MAX_RUN=3, ALARM=1.
- Samples alternating -1,1 (x4 each), with OUT_READY low for 5 cycles -> OUT_VALID and fields stable at NEG_COUNT=4, MAX_RUN=1, ALARM=0; IN_READY=0 throughout; the result is consumed when OUT_READY rises.
- CONT=1 at the handshake, next window all 8'h80 -> counters restart, no run carry-over; NEG_COUNT=8, MAX_RUN=8, ALARM=1; then CONT=0 -> IDLE with BUSY=0.
- IN_VALID gapped (valid every 3rd cycle) over a window of 7 negatives then 1 positive -> only valid cycles counted; NEG_COUNT=7, MAX_RUN=7.
- RST_N low after 5 accepted samples, then START and 8 samples of 0 -> no result from the aborted window; next result NEG_COUNT=0, MAX_RUN=0.

Source files
------------

// File: rtl/sign_window_monitor.sv
// sign_window_monitor: per-window negative-sample statistics on a
// valid/ready sample stream, reported over a valid/ready result port.
module sign_window_monitor #(
  parameter int WIDTH     = 8,
  parameter int WINDOW    = 16,
  parameter int RUN_LIMIT = 4,
  localparam int CW       = $clog2(WINDOW + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             CONT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CW-1:0]    NEG_COUNT,
  output logic [CW-1:0]    MAX_RUN,
  output logic             ALARM,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_REPORT
  } state_t;

  state_t        state;
  logic [CW-1:0] smp_cnt;
  logic [CW-1:0] neg_cnt;
  logic [CW-1:0] run;
  logic [CW-1:0] max_run_q;

  logic          neg;
  logic          last;
  logic [CW-1:0] neg_next;
  logic [CW-1:0] run_next;
  logic [CW-1:0] max_next;

  assign neg      = A[WIDTH-1];
  assign last     = (smp_cnt == CW'(WINDOW - 1));
  assign neg_next = neg_cnt + CW'(neg);
  assign run_next = neg ? run + CW'(1) : '0;
  assign max_next = (run_next > max_run_q) ? run_next : max_run_q;

  assign IN_READY  = (state == S_COUNT);
  assign OUT_VALID = (state == S_REPORT);
  assign BUSY      = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      smp_cnt   <= '0;
      neg_cnt   <= '0;
      run       <= '0;
      max_run_q <= '0;
      NEG_COUNT <= '0;
      MAX_RUN   <= '0;
      ALARM     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            state     <= S_COUNT;
            smp_cnt   <= '0;
            neg_cnt   <= '0;
            run       <= '0;
            max_run_q <= '0;
          end
        end
        S_COUNT: begin
          if (IN_VALID) begin
            smp_cnt   <= smp_cnt + CW'(1);
            neg_cnt   <= neg_next;
            run       <= run_next;
            max_run_q <= max_next;
            // Close on the WINDOW-th sample, folding it into the result
            if (last) begin
              state     <= S_REPORT;
              NEG_COUNT <= neg_next;
              MAX_RUN   <= max_next;
              ALARM     <= (max_next >= CW'(RUN_LIMIT));
            end
          end
        end
        S_REPORT: begin
          if (OUT_READY) begin
            if (CONT) begin
              state     <= S_COUNT;
              smp_cnt   <= '0;
              neg_cnt   <= '0;
              run       <= '0;
              max_run_q <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_window_monitor.sv
// tb_sign_window_monitor: directed vectors with hand-computed results
// for sign_window_monitor at WINDOW=8, RUN_LIMIT=3.
module tb_sign_window_monitor;

  localparam int WIDTH = 8;
  localparam int WIN   = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             cont;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    neg_count;
  logic [CW-1:0]    max_run;
  logic             alarm;
  logic             busy;

  int checks;
  int errors;

  sign_window_monitor #(
    .WIDTH    (WIDTH),
    .WINDOW   (WIN),
    .RUN_LIMIT(3)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .CONT     (cont),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .A        (a),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .NEG_COUNT(neg_count),
    .MAX_RUN  (max_run),
    .ALARM    (alarm),
    .BUSY     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] s, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = s;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake(input logic c);
    out_ready = 1'b1;
    cont = c;
    tick();
    out_ready = 1'b0;
    cont = 1'b0;
  endtask

  task automatic exp_result(input string tag, input int nc,
                            input int mr, input int al);
    chk({tag, "_ov"}, int'(out_valid), 1);
    chk({tag, "_rdy"}, int'(in_ready), 0);
    chk({tag, "_neg"}, int'(neg_count), nc);
    chk({tag, "_max"}, int'(max_run), mr);
    chk({tag, "_alm"}, int'(alarm), al);
  endtask

  logic [7:0] w2 [WIN] = '{8'hFF, 8'hFE, 8'h05, 8'hFD,
                           8'hFC, 8'hFB, 8'h00, 8'h80};

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cont = 1'b0;
    in_valid = 1'b0;
    a = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_rdy", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alm", int'(alarm), 0);
    chk("rst_neg", int'(neg_count), 0);
    chk("rst_max", int'(max_run), 0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores a held sample
    in_valid = 1'b1;
    a = 8'hFF;
    repeat (3) tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_rdy", int'(in_ready), 0);
    in_valid = 1'b0;

    // Window 1: 0..7
    pulse_start();
    chk("w1_busy", int'(busy), 1);
    chk("w1_rdy", int'(in_ready), 1);
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) chk("w1_ov_early", int'(out_valid), 0);
      send_one(8'(i), 0);
    end
    exp_result("w1", 0, 0, 0);
    handshake(1'b0);
    chk("w1_idle", int'(busy), 0);
    chk("w1_ov_off", int'(out_valid), 0);
    chk("w1_hold_neg", int'(neg_count), 0);

    // Window 2: mixed, includes 0 and -128
    pulse_start();
    for (int i = 0; i < WIN; i++) send_one(w2[i], 0);
    exp_result("w2", 6, 3, 1);
    handshake(1'b0);
    chk("w2_hold_neg", int'(neg_count), 6);
    chk("w2_hold_alm", int'(alarm), 1);

    // Window 3: alternating, with backpressure
    pulse_start();
    for (int i = 0; i < WIN; i++)
      send_one((i % 2 == 0) ? 8'hFF : 8'h01, 0);
    in_valid = 1'b1;
    a = 8'h80;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_result("w3_stall", 4, 1, 0);
      chk("w3_busy", int'(busy), 1);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    exp_result("w3", 4, 1, 0);
    handshake(1'b1);
    chk("w3_ov_off", int'(out_valid), 0);
    chk("w3_cont_rdy", int'(in_ready), 1);

    // Window 4: all -128 immediately after CONT
    for (int i = 0; i < WIN; i++) send_one(8'h80, 0);
    exp_result("w4", 8, 8, 1);
    handshake(1'b0);
    chk("w4_busy", int'(busy), 0);
    chk("w4_rdy", int'(in_ready), 0);

    // Window 5: gapped valid
    pulse_start();
    for (int i = 0; i < WIN; i++)
      send_one((i < 7) ? 8'hFF : 8'h01, 2);
    exp_result("w5", 7, 7, 1);
    handshake(1'b0);

    // Abort mid-window with reset
    pulse_start();
    for (int i = 0; i < 5; i++) send_one(8'hFF, 0);
    rst_n = 1'b0;
    #2;
    chk("ab_busy", int'(busy), 0);
    chk("ab_ov", int'(out_valid), 0);
    chk("ab_neg", int'(neg_count), 0);
    chk("ab_alm", int'(alarm), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("ab_no_res", int'(out_valid), 0);
    pulse_start();
    for (int i = 0; i < WIN; i++) send_one(8'h00, 0);
    exp_result("w6", 0, 0, 0);
    handshake(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
